mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
Multi-cycle control FSM that sequences the shared ALU, register file, PC and unified instruction/data memory port for the MIPS subset, replacing the single-cycle controller. It decodes op/funct from the latched IR. Each cycle it drives ALUOp, mux selects and write strobes, and consumes the ALU zero flag for branches. Memory accesses use a ready handshake so slow memory stalls the FSM.

Parameters:
RA_IDX, 31, register index written by jal
PC_STEP, 4, constant selected on alu_srcb=1 (informational; fixed at 4)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
op  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag; ALU sets it to 1 when the branch is taken for both EQL and BNE
mem_ready  in  1  memory has completed the current access this cycle
alu_op  out  5  ALU operation, team ALUOp_* encodings
alu_srca  out  2  0=PC, 1=reg A (rs), 2=reg B (rt)
alu_srcb  out  2  0=reg B, 1=constant 4, 2=ext imm, 3=ext imm<<2
ext_op  out  1  1=sign-extend imm, 0=zero-extend
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  latch instruction register and MDR
pc_en  out  1  PC load enable
npc_sel  out  2  0=ALU result, 1=ALUOut register, 2=jump target {PC[31:28],IR[25:0],00}
reg_write  out  1  register file write enable
wr_sel  out  2  0=rd, 1=rt, 2=RA_IDX
wd_sel  out  2  0=ALUOut, 1=MDR, 2=PC
state  out  3  current state, for debug

Behaviour:
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. The state register is reset asynchronously to IF.
- All other outputs are combinational from state, op, funct, zero and mem_ready.
- While rst=1: pc_en, ir_write, reg_write and mem_write are forced to 0.
- Default for any output not listed in a state: 0.
- IF: mem_read=1, alu_srca=0, alu_srcb=1, alu_op=ADDU.
  - If mem_ready=1: ir_write=1, pc_en=1, npc_sel=0, go to ID.
  - Otherwise stay in IF with no strobes asserted.
- ID: alu_srca=0, alu_srcb=3, ext_op=1, alu_op=ADDU; ALUOut captures the branch target.
  - j: pc_en=1, npc_sel=2, go to IF.
  - jal: additionally reg_write=1, wr_sel=2, wd_sel=2 (PC already holds PC+4), go to IF.
  - Any other legal op: go to EX.
- EX:
  - R-type: alu_srca=1, alu_srcb=0. Exception: sll uses alu_srca=2, alu_srcb=2. Go to WB.
  - addi: srca=1, srcb=2, ext_op=1, ADD. ori: srca=1, srcb=2, ext_op=0, OR. lui: srcb=2, LUI. Each goes to WB.
  - lw/sw: srca=1, srcb=2, ext_op=1, ADDU, go to MEM.
  - beq/bne: srca=1, srcb=0, alu_op=EQL or BNE respectively; pc_en=zero, npc_sel=1, go to IF.
- R-type funct to alu_op mapping:
  - 100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU
  - 100101 OR, 101010 SLT, 000000 SLL
- MEM: lw asserts mem_read=1; sw asserts mem_write=1. Both hold in MEM until mem_ready=1. On mem_ready, lw goes to WB and sw goes to IF.
- WB: reg_write=1.
  - R-type: wr_sel=0, wd_sel=0.
  - addi/ori/lui: wr_sel=1, wd_sel=0.
  - lw: wr_sel=1, wd_sel=1.
  - Go to IF.
- Opcodes:
  - R=000000, lw=100011, sw=101011, beq=000100, bne=000101
  - addi=001000, ori=001101, lui=001111, j=000010, jal=000011
- Latency (zero-wait memory):
  - j/jal: 2 cycles; beq/bne: 3; R/I ALU ops and sw: 4; lw: 5.
  - Each wait cycle adds 1.
- Reset mid-instruction aborts it; no register or memory write occurs after rst rises.
- mem_ready asserted outside IF/MEM is ignored.

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Defined: an undecoded op, or an undecoded funct under R-type, detected in ID goes to HALT. HALT asserts no strobes and is left only by reset. Adds output illegal (1 bit), which is 1 in HALT.
- Undefined: an undecoded instruction goes from ID directly to IF with no writes (NOP); HALT is unreachable and the illegal port is absent.

Test Plan:
- Reset then addu with mem_ready=1 -> states IF,ID,EX,WB,IF; alu_op=ADDU in EX; reg_write=1, wr_sel=0 only in WB; pc_en only in IF.
- lw with mem_ready low for 2 cycles in IF and 3 cycles in MEM -> 10 total cycles; exactly one ir_write pulse and one reg_write pulse with wd_sel=1.
- beq with zero=1 -> EX: pc_en=1, npc_sel=1. Repeat with zero=0 -> pc_en=0. bne in EX -> alu_op=BNE.
- jal -> 2 cycles; ID: pc_en=1, npc_sel=2, reg_write=1, wr_sel=2, wd_sel=2.
- ori in EX -> ext_op=0, alu_op=OR, srcb=2. sll in EX -> srca=2, srcb=2, alu_op=SLL.
- sw stalled in MEM with mem_write=1, assert rst -> state=IF immediately, mem_write=0, no reg_write. With ILLEGAL_TRAP_EN, op=111111 -> HALT, illegal=1, held until rst.

Source files
------------

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl
//  Purpose  : Multi-cycle control FSM for the MIPS subset. Sequences the
//             shared ALU, register file, PC and the unified instruction/data
//             memory port. Memory accesses wait on mem_ready.
//  Options  : ILLEGAL_TRAP_EN - undecoded instructions trap to HALT and the
//             'illegal' output is added. Undefined: they retire as NOPs.
//  Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl #(
  parameter int RA_IDX  = 31,  // register written by jal (selected by wr_sel=2)
  parameter int PC_STEP = 4    // constant on alu_srcb=1, fixed at 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [4:0] alu_op,
  output logic [1:0] alu_srca,
  output logic [1:0] alu_srcb,
  output logic       ext_op,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] npc_sel,
  output logic       reg_write,
  output logic [1:0] wr_sel,
  output logic [1:0] wd_sel,
`ifdef ILLEGAL_TRAP_EN
  output logic       illegal,
`endif
  output logic [2:0] state
);

  // The datapath hard-wires these two values; reject any other setting.
  if (PC_STEP != 4 || RA_IDX != 31) begin : g_param_check
    $error("mc_ctrl: PC_STEP must be 4 and RA_IDX must be 31");
  end

  // ALU operation encodings shared with the ALU.
  localparam logic [4:0] ALUOP_ADD  = 5'd0;
  localparam logic [4:0] ALUOP_ADDU = 5'd1;
  localparam logic [4:0] ALUOP_SUB  = 5'd2;
  localparam logic [4:0] ALUOP_SUBU = 5'd3;
  localparam logic [4:0] ALUOP_OR   = 5'd4;
  localparam logic [4:0] ALUOP_SLT  = 5'd5;
  localparam logic [4:0] ALUOP_SLL  = 5'd6;
  localparam logic [4:0] ALUOP_LUI  = 5'd7;
  localparam logic [4:0] ALUOP_EQL  = 5'd8;
  localparam logic [4:0] ALUOP_BNE  = 5'd9;

  // Primary opcodes.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes.
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic       is_rtype, is_lw, is_sw, is_beq, is_bne;
  logic       is_addi, is_ori, is_lui, is_j, is_jal;
  logic       is_sll;
  logic       r_legal, insn_legal;
  logic [4:0] r_alu_op;

  // Strobes before the reset override.
  logic pc_en_raw, ir_write_raw, reg_write_raw, mem_write_raw;

  // Opcode decode of the latched IR.
  always_comb begin
    is_rtype = (op == OP_RTYPE);
    is_lw    = (op == OP_LW);
    is_sw    = (op == OP_SW);
    is_beq   = (op == OP_BEQ);
    is_bne   = (op == OP_BNE);
    is_addi  = (op == OP_ADDI);
    is_ori   = (op == OP_ORI);
    is_lui   = (op == OP_LUI);
    is_j     = (op == OP_J);
    is_jal   = (op == OP_JAL);
    is_sll   = is_rtype && (funct == FN_SLL);
  end

  // R-type funct to ALU operation; r_legal flags a recognised funct.
  always_comb begin
    r_alu_op = ALUOP_ADD;
    r_legal  = 1'b1;
    case (funct)
      FN_ADD:  r_alu_op = ALUOP_ADD;
      FN_ADDU: r_alu_op = ALUOP_ADDU;
      FN_SUB:  r_alu_op = ALUOP_SUB;
      FN_SUBU: r_alu_op = ALUOP_SUBU;
      FN_OR:   r_alu_op = ALUOP_OR;
      FN_SLT:  r_alu_op = ALUOP_SLT;
      FN_SLL:  r_alu_op = ALUOP_SLL;
      default: r_legal  = 1'b0;
    endcase
  end

  // Whole-instruction legality, used by ID to pick EX or the illegal path.
  always_comb begin
    insn_legal = (is_rtype && r_legal) || is_lw || is_sw || is_beq || is_bne ||
                 is_addi || is_ori || is_lui || is_j || is_jal;
  end

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control outputs.
  always_comb begin
    state_d       = state_q;
    alu_op        = ALUOP_ADD;
    alu_srca      = 2'd0;
    alu_srcb      = 2'd0;
    ext_op        = 1'b0;
    mem_read      = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    pc_en_raw     = 1'b0;
    npc_sel       = 2'd0;
    reg_write_raw = 1'b0;
    wr_sel        = 2'd0;
    wd_sel        = 2'd0;

    case (state_q)
      S_IF: begin
        // Fetch and compute PC+4 in the same cycle.
        mem_read = 1'b1;
        alu_srca = 2'd0;
        alu_srcb = 2'd1;
        alu_op   = ALUOP_ADDU;
        if (mem_ready) begin
          ir_write_raw = 1'b1;
          pc_en_raw    = 1'b1;
          npc_sel      = 2'd0;
          state_d      = S_ID;
        end
      end

      S_ID: begin
        // Speculatively compute the branch target into ALUOut.
        alu_srca = 2'd0;
        alu_srcb = 2'd3;
        ext_op   = 1'b1;
        alu_op   = ALUOP_ADDU;
        if (is_j) begin
          pc_en_raw = 1'b1;
          npc_sel   = 2'd2;
          state_d   = S_IF;
        end else if (is_jal) begin
          // PC already holds PC+4, which is the link value.
          pc_en_raw     = 1'b1;
          npc_sel       = 2'd2;
          reg_write_raw = 1'b1;
          wr_sel        = 2'd2;
          wd_sel        = 2'd2;
          state_d       = S_IF;
        end else if (insn_legal) begin
          state_d = S_EX;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_IF;
`endif
        end
      end

      S_EX: begin
        state_d = S_IF;
        if (is_rtype) begin
          alu_op = r_alu_op;
          if (is_sll) begin
            alu_srca = 2'd2;
            alu_srcb = 2'd2;
          end else begin
            alu_srca = 2'd1;
            alu_srcb = 2'd0;
          end
          state_d = S_WB;
        end else if (is_addi) begin
          alu_srca = 2'd1;
          alu_srcb = 2'd2;
          ext_op   = 1'b1;
          alu_op   = ALUOP_ADD;
          state_d  = S_WB;
        end else if (is_ori) begin
          alu_srca = 2'd1;
          alu_srcb = 2'd2;
          ext_op   = 1'b0;
          alu_op   = ALUOP_OR;
          state_d  = S_WB;
        end else if (is_lui) begin
          alu_srcb = 2'd2;
          alu_op   = ALUOP_LUI;
          state_d  = S_WB;
        end else if (is_lw || is_sw) begin
          alu_srca = 2'd1;
          alu_srcb = 2'd2;
          ext_op   = 1'b1;
          alu_op   = ALUOP_ADDU;
          state_d  = S_MEM;
        end else if (is_beq || is_bne) begin
          // The ALU raises zero when the branch is taken for either sense.
          alu_srca  = 2'd1;
          alu_srcb  = 2'd0;
          alu_op    = is_beq ? ALUOP_EQL : ALUOP_BNE;
          pc_en_raw = zero;
          npc_sel   = 2'd1;
          state_d   = S_IF;
        end
      end

      S_MEM: begin
        // Hold the request until memory reports completion.
        mem_read      = is_lw;
        mem_write_raw = is_sw;
        if (mem_ready) begin
          state_d = is_lw ? S_WB : S_IF;
        end
      end

      S_WB: begin
        reg_write_raw = 1'b1;
        if (is_rtype) begin
          wr_sel = 2'd0;
          wd_sel = 2'd0;
        end else if (is_lw) begin
          wr_sel = 2'd1;
          wd_sel = 2'd1;
        end else begin
          wr_sel = 2'd1;
          wd_sel = 2'd0;
        end
        state_d = S_IF;
      end

      S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = S_HALT;
`else
        state_d = S_IF;
`endif
      end

      default: state_d = S_IF;
    endcase
  end

  // Architectural strobes are suppressed for as long as reset is high.
  assign pc_en     = pc_en_raw     & ~rst;
  assign ir_write  = ir_write_raw  & ~rst;
  assign reg_write = reg_write_raw & ~rst;
  assign mem_write = mem_write_raw & ~rst;

  assign state = state_q;

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (state_q == S_HALT);
`endif

endmodule
`default_nettype wire
